// File: rtl/drive_arbiter.sv
// Actuator command owner: fixed-priority arbitration of four motion requesters,
// reversal sequencing (brake/dwell), speed ramp and ultrasonic safety stops.
// Optional macro DRIVE_ARB_RAMP_EN: per-tick speed ramp; when undefined speed steps directly.
module drive_arbiter #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned MIN_HOLD_MS = 100,
    parameter int unsigned WDOG_MS     = 200,
    parameter int unsigned DWELL_MS    = 300,
    parameter int unsigned RAMP_STEP   = 2,
    parameter int unsigned SAFE_FWD    = 20,
    parameter int unsigned SAFE_BACK   = 9,
    parameter int unsigned DEG_MIN     = 30,
    parameter int unsigned DEG_MAX     = 150,
    parameter int unsigned DEG_CENTER  = 95
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic        req_strobe0,
    input  logic [31:0] req_speed,
    input  logic [35:0] req_degree,
    input  logic [3:0]  req_dir,
    input  logic [7:0]  forwardDistance,
    input  logic [7:0]  backDistance,
    output logic [7:0]  speed,
    output logic [8:0]  degree,
    output logic        direction,
    output logic [3:0]  grant,
    output logic [1:0]  grant_id,
    output logic        safety_stop,
    output logic        busy_rev
);

    localparam int unsigned TDIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned MS_W   = 16;

    localparam logic [8:0] DEG_MIN_W    = 9'(DEG_MIN);
    localparam logic [8:0] DEG_MAX_W    = 9'(DEG_MAX);
    localparam logic [8:0] DEG_CENTER_W = 9'(DEG_CENTER);
    localparam logic [7:0] SAFE_FWD_W   = 8'(SAFE_FWD);
    localparam logic [7:0] SAFE_BACK_W  = 8'(SAFE_BACK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_BRAKE = 2'd2,
        ST_DWELL = 2'd3
    } state_t;

    state_t            state;
    logic [TDIV_W-1:0] tick_cnt;
    logic              tick_c;
    logic [MS_W-1:0]   wdog_cnt;
    logic [MS_W-1:0]   hold_cnt;
    logic [MS_W-1:0]   dwell_cnt;
    logic [3:0]        eff_valid;
    logic              hi_any;
    logic [1:0]        hi_id;
    logic              owner_c;
    logic              gnt_any_nxt;
    logic [1:0]        gnt_id_nxt;
    logic [3:0]        grant_nxt;
    logic [7:0]        spd_a [4];
    logic [8:0]        deg_a [4];
    logic [7:0]        tgt_speed;
    logic [8:0]        tgt_deg_raw;
    logic [8:0]        tgt_deg;
    logic              tgt_dir;
    logic              safe_c;
    logic [7:0]        spd_goal;
    logic [7:0]        spd_step_c;

    // Free-running millisecond tick
    assign tick_c = (tick_cnt == TDIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)      tick_cnt <= '0;
        else if (tick_c) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + 1'b1;
    end

    // Remote watchdog; a fresh strobe outranks a same-cycle tick decrement
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)                        wdog_cnt <= '0;
        else if (req_strobe0)              wdog_cnt <= MS_W'(WDOG_MS);
        else if (tick_c && wdog_cnt != '0) wdog_cnt <= wdog_cnt - 1'b1;
    end

    assign eff_valid = {req_valid[3:1], req_valid[0] && (wdog_cnt != '0)};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            spd_a[i] = req_speed[8*i +: 8];
            deg_a[i] = req_degree[9*i +: 9];
        end
    end

    // Highest-priority effective requester (index 0 wins)
    always_comb begin
        hi_any = |eff_valid;
        hi_id  = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eff_valid[i]) hi_id = 2'(i);
        end
    end

    assign owner_c = |grant;

    always_comb begin
        gnt_any_nxt = owner_c;
        gnt_id_nxt  = grant_id;
        if (!owner_c || !eff_valid[grant_id]) begin
            gnt_any_nxt = hi_any;
            gnt_id_nxt  = hi_any ? hi_id : 2'd0;
        end else if (hi_any && (hi_id < grant_id) && (hold_cnt == '0)) begin
            gnt_id_nxt = hi_id;
        end
        grant_nxt = gnt_any_nxt ? (4'b0001 << gnt_id_nxt) : 4'b0000;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= 4'b0000;
            grant_id <= 2'd0;
            hold_cnt <= '0;
        end else begin
            grant    <= grant_nxt;
            grant_id <= gnt_id_nxt;
            if (grant_nxt != grant)            hold_cnt <= MS_W'(MIN_HOLD_MS);
            else if (tick_c && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Targets from the current owner, idle defaults otherwise
    always_comb begin
        tgt_speed   = owner_c ? spd_a[grant_id]   : 8'd0;
        tgt_deg_raw = owner_c ? deg_a[grant_id]   : DEG_CENTER_W;
        tgt_dir     = owner_c ? req_dir[grant_id] : direction;
        if (tgt_deg_raw < DEG_MIN_W)      tgt_deg = DEG_MIN_W;
        else if (tgt_deg_raw > DEG_MAX_W) tgt_deg = DEG_MAX_W;
        else                              tgt_deg = tgt_deg_raw;
    end

    assign safe_c = direction ? (forwardDistance < SAFE_FWD_W)
                              : (backDistance < SAFE_BACK_W);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            degree      <= DEG_CENTER_W;
            safety_stop <= 1'b0;
        end else begin
            degree      <= tgt_deg;
            safety_stop <= safe_c;
        end
    end

    assign spd_goal = (state == ST_DRIVE) ? tgt_speed : 8'd0;

`ifdef DRIVE_ARB_RAMP_EN
    localparam logic [7:0] STEP_W = 8'(RAMP_STEP);

    // Move toward tgt by at most STEP_W without passing it
    function automatic logic [7:0] ramp_f(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] diff;
        if (cur < tgt) begin
            diff = tgt - cur;
            return (diff > STEP_W) ? (cur + STEP_W) : tgt;
        end else begin
            diff = cur - tgt;
            return (diff > STEP_W) ? (cur - STEP_W) : tgt;
        end
    endfunction

    assign spd_step_c = tick_c ? ramp_f(speed, spd_goal) : speed;
`else
    assign spd_step_c = spd_goal;
`endif

    // Motion FSM: a started reversal always runs through brake and dwell
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            speed     <= 8'd0;
            direction <= 1'b1;
            busy_rev  <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            speed <= safe_c ? 8'd0 : spd_step_c;
            case (state)
                ST_IDLE: begin
                    if (owner_c) begin
                        if (tgt_dir == direction) begin
                            state <= ST_DRIVE;
                        end else begin
                            state    <= ST_BRAKE;
                            busy_rev <= 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    if (!owner_c) begin
                        state <= ST_IDLE;
                    end else if (tgt_dir != direction) begin
                        state    <= ST_BRAKE;
                        busy_rev <= 1'b1;
                    end
                end
                ST_BRAKE: begin
                    if (speed == 8'd0) begin
                        state     <= ST_DWELL;
                        dwell_cnt <= MS_W'(DWELL_MS);
                    end
                end
                ST_DWELL: begin
                    if (dwell_cnt == '0) begin
                        direction <= tgt_dir;
                        state     <= owner_c ? ST_DRIVE : ST_IDLE;
                        busy_rev  <= 1'b0;
                    end else if (tick_c) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_rev <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter with a short tick (4 clocks per ms).
module tb_drive_arbiter;

    logic        clk_50M = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic        req_strobe0;
    logic [31:0] req_speed;
    logic [35:0] req_degree;
    logic [3:0]  req_dir;
    logic [7:0]  forwardDistance;
    logic [7:0]  backDistance;
    logic [7:0]  speed;
    logic [8:0]  degree;
    logic        direction;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        safety_stop;
    logic        busy_rev;

    int checks = 0;
    int errors = 0;

    drive_arbiter #(.TICK_DIV(4)) dut (
        .clk_50M         (clk_50M),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_strobe0     (req_strobe0),
        .req_speed       (req_speed),
        .req_degree      (req_degree),
        .req_dir         (req_dir),
        .forwardDistance (forwardDistance),
        .backDistance    (backDistance),
        .speed           (speed),
        .degree          (degree),
        .direction       (direction),
        .grant           (grant),
        .grant_id        (grant_id),
        .safety_stop     (safety_stop),
        .busy_rev        (busy_rev)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] sp,
                           input logic [8:0] dg, input logic d);
        req_valid[i]        = v;
        req_speed[8*i +: 8] = sp;
        req_degree[9*i +: 9] = dg;
        req_dir[i]          = d;
    endtask

    task automatic pulse_strobe();
        req_strobe0 = 1'b1;
        cyc(1);
        req_strobe0 = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_speed"},  32'(speed),       32'd0);
        check({tag, "_degree"}, 32'(degree),      32'd95);
        check({tag, "_dir"},    32'(direction),   32'd1);
        check({tag, "_grant"},  32'(grant),       32'd0);
        check({tag, "_gid"},    32'(grant_id),    32'd0);
        check({tag, "_safe"},   32'(safety_stop), 32'd0);
        check({tag, "_busy"},   32'(busy_rev),    32'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        req_valid       = '0;
        req_strobe0     = 1'b0;
        req_speed       = '0;
        req_degree      = '0;
        req_dir         = '0;
        forwardDistance = 8'd100;
        backDistance    = 8'd100;
        #12;
        check_reset_values("rst");
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // Single requester basic drive
        set_req(2, 1'b1, 8'd30, 9'd120, 1'b1);
        cyc(1);
        check("basic_grant", 32'(grant), 32'h4);
        check("basic_gid", 32'(grant_id), 32'd2);
        cyc(2);
        check("basic_degree", 32'(degree), 32'd120);
`ifdef DRIVE_ARB_RAMP_EN
        cyc(17);
        check("basic_midramp", 32'((speed > 8'd0) && (speed < 8'd30)), 32'd1);
        cyc(60);
`else
        cyc(77);
`endif
        check("basic_speed", 32'(speed), 32'd30);
        check("basic_dir", 32'(direction), 32'd1);

        // Degree clamp limits
        set_req(2, 1'b1, 8'd30, 9'd200, 1'b1);
        cyc(3);
        check("clamp_hi", 32'(degree), 32'd150);
        set_req(2, 1'b1, 8'd30, 9'd10, 1'b1);
        cyc(3);
        check("clamp_lo", 32'(degree), 32'd30);
        set_req(2, 1'b1, 8'd30, 9'd150, 1'b1);
        cyc(3);
        check("clamp_edge", 32'(degree), 32'd150);

        // Forward safety stop
        forwardDistance = 8'd20;
        cyc(1);
        check("safe_f20", 32'(safety_stop), 32'd0);
        check("safe_f20_spd", 32'(speed), 32'd30);
        forwardDistance = 8'd19;
        cyc(1);
        check("safe_f19", 32'(safety_stop), 32'd1);
        check("safe_f19_spd", 32'(speed), 32'd0);
        cyc(10);
        check("safe_hold_spd", 32'(speed), 32'd0);
        forwardDistance = 8'd25;
        cyc(1);
        check("safe_clear", 32'(safety_stop), 32'd0);
        cyc(80);
        check("safe_resume", 32'(speed), 32'd30);

        // Direction reversal at speed 20
        set_req(2, 1'b1, 8'd20, 9'd120, 1'b1);
        cyc(80);
        check("rev_pre_spd", 32'(speed), 32'd20);
        set_req(2, 1'b1, 8'd20, 9'd120, 1'b0);
        cyc(2);
        check("rev_busy", 32'(busy_rev), 32'd1);
        check("rev_dir_hold", 32'(direction), 32'd1);
        cyc(58);
        check("rev_brake_done", 32'(speed), 32'd0);
        cyc(1040);
        check("rev_dwell_busy", 32'(busy_rev), 32'd1);
        check("rev_dwell_dir", 32'(direction), 32'd1);
        check("rev_dwell_spd", 32'(speed), 32'd0);
        cyc(200);
        check("rev_done_dir", 32'(direction), 32'd0);
        check("rev_done_busy", 32'(busy_rev), 32'd0);
        cyc(100);
        check("rev_ramp_up", 32'(speed), 32'd20);

        // Reverse safety uses the rear limit
        backDistance = 8'd9;
        cyc(1);
        check("safe_b9", 32'(safety_stop), 32'd0);
        backDistance = 8'd8;
        cyc(1);
        check("safe_b8", 32'(safety_stop), 32'd1);
        check("safe_b8_spd", 32'(speed), 32'd0);
        backDistance = 8'd100;
        cyc(2);

        // Async reset in the middle of a dwell
        set_req(2, 1'b1, 8'd20, 9'd60, 1'b1);
        cyc(200);
        check("dwell_pre_busy", 32'(busy_rev), 32'd1);
        check("dwell_pre_deg", 32'(degree), 32'd60);
        rst_n = 1'b0;
        #2;
        check_reset_values("arst");
        req_valid = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        // Preemption blocked until the hold time expires
        set_req(3, 1'b1, 8'd10, 9'd90, 1'b1);
        cyc(1);
        check("pre_r3", 32'(grant), 32'h8);
        cyc(159);
        set_req(0, 1'b1, 8'd15, 9'd100, 1'b1);
        pulse_strobe();
        cyc(230);
        check("pre_held", 32'(grant), 32'h8);
        cyc(20);
        check("pre_switch", 32'(grant), 32'h1);
        check("pre_gid", 32'(grant_id), 32'd0);

        // Owner dropping valid moves the grant at once
        req_valid[0] = 1'b0;
        cyc(1);
        check("drop_to_r3", 32'(grant), 32'h8);
        cyc(199);
        req_valid[0] = 1'b1;
        pulse_strobe();
        cyc(5);
        check("drop_held", 32'(grant), 32'h8);
        req_valid[3] = 1'b0;
        cyc(1);
        check("drop_switch", 32'(grant), 32'h1);

        // Watchdog expiry hands over to requester 2, then to none
        set_req(2, 1'b1, 8'd40, 9'd95, 1'b1);
        cyc(770);
        check("wdog_alive", 32'(grant), 32'h1);
        cyc(30);
        check("wdog_expired", 32'(grant), 32'h4);
        check("wdog_gid", 32'(grant_id), 32'd2);
        cyc(100);
        check("wdog_r2_spd", 32'(speed), 32'd40);
        req_valid[2] = 1'b0;
        cyc(1);
        check("none_grant", 32'(grant), 32'h0);
        cyc(100);
        check("none_spd", 32'(speed), 32'd0);
        check("none_deg", 32'(degree), 32'd95);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/drive_arbiter.md
Name: drive_arbiter

Overview:
- Owns the actuator command bus (speed, degree, direction) that feeds the motor PWM and the steering servo.
- Arbitrates among four motion requesters with fixed priority: 0 = Zigbee remote, 1 = obstacle avoidance, 2 = line tracking, 3 = parking/cruise.
- Sequences direction reversals through a brake/dwell state machine, ramps speed, and applies ultrasonic safety stops.
- Sits between the mode logic and the motor/servo drivers.

Parameters:
- TICK_DIV, 50000: clk_50M cycles per 1 ms tick.
- MIN_HOLD_MS, 100: minimum grant tenure before preemption by a higher-priority requester.
- WDOG_MS, 200: requester 0 is treated as invalid if req_strobe0 is absent for this many ticks.
- DWELL_MS, 300: zero-speed dwell before a direction flip.
- RAMP_STEP, 2: speed change per tick.
- SAFE_FWD, 20: forward stop distance in cm.
- SAFE_BACK, 9: reverse stop distance in cm.
- DEG_MIN, 30; DEG_MAX, 150; DEG_CENTER, 95: servo clamp limits and idle angle.

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  4  per-requester request valid.
- req_strobe0  in  1  one-cycle pulse on each fresh remote command.
- req_speed  in  32  {r3,r2,r1,r0}, 8 bits each.
- req_degree  in  36  {r3,r2,r1,r0}, 9 bits each.
- req_dir  in  4  per-requester direction (1 = forward).
- forwardDistance  in  8  front ultrasonic, cm.
- backDistance  in  8  rear ultrasonic, cm.
- speed  out  8  motor speed command.
- degree  out  9  servo angle.
- direction  out  1  1 = forward, 0 = reverse.
- grant  out  4  one-hot owner; 0 = none.
- grant_id  out  2  encoded owner.
- safety_stop  out  1  high while a distance limit forces zero speed.
- busy_rev  out  1  high during the BRAKE and DWELL states.

Behaviour:
- Reset (async, rst_n low) values: speed=0, degree=DEG_CENTER, direction=1, grant=0, grant_id=0, safety_stop=0, busy_rev=0, FSM=IDLE, tick divider=0, hold counter=0, watchdog counter=0.
- Tick: free-running divider; tick is a one-cycle pulse every TICK_DIV cycles. All millisecond counters decrement on tick only and saturate at 0.
- Watchdog: req_strobe0 reloads the counter to WDOG_MS. eff_valid[0] = req_valid[0] && counter != 0. eff_valid[3:1] = req_valid[3:1].
- Arbitration, evaluated every clock:
  - If the owner drops eff_valid, the grant moves to the highest-priority eff_valid requester, or to none.
  - A higher-priority eff_valid requester preempts only when the hold counter is 0.
  - Every grant change reloads the hold counter to MIN_HOLD_MS.
  - grant and grant_id are registered, giving 1-cycle latency.
- Target selection:
  - From the owner: tgt_speed, tgt_deg and tgt_dir.
  - With no owner: tgt_speed=0, tgt_deg=DEG_CENTER, tgt_dir=current direction.
  - tgt_deg is clamped to [DEG_MIN, DEG_MAX].
  - degree = clamped tgt_deg, registered (1-cycle latency); it follows the target in every FSM state.
- Safety: safety_stop is a registered compare of the current direction against its distance limit.
  - Set when direction==1 && forwardDistance < SAFE_FWD.
  - Set when direction==0 && backDistance < SAFE_BACK.
  - While safety_stop is high, speed is forced to 0 on the next clock, with no ramp.
- FSM:
  - IDLE: speed ramps to 0. Go to DRIVE when an owner exists and tgt_dir==direction. Go to BRAKE when an owner exists and tgt_dir!=direction.
  - DRIVE: speed ramps toward tgt_speed. Go to BRAKE if tgt_dir!=direction. Go to IDLE if the grant becomes none.
  - BRAKE: speed ramps toward 0. When speed==0, go to DWELL and load the dwell counter with DWELL_MS.
  - DWELL: speed=0. When the counter reaches 0: direction takes tgt_dir, and the FSM goes to DRIVE, or to IDLE if there is no owner. If tgt_dir returns to the old direction during BRAKE or DWELL, the sequence still completes and the flip is skipped.
- Ramp, on each tick:
  - speed moves by min(RAMP_STEP, |tgt−speed|) toward the target.
  - No overflow or underflow: the result is bounded by 0 and by tgt_speed.
- Simultaneous events:
  - safety_stop wins over the ramp.
  - A grant change during BRAKE/DWELL does not abort the reversal.
  - Tick and strobe in the same cycle: the strobe reload wins.
- Reset mid-operation: immediate return to the reset values, including during DWELL.

Optional Feature:
- DRIVE_ARB_RAMP_EN defined: speed ramps as specified above.
- Undefined: speed takes the target value on the next clock in DRIVE, and reaches 0 on the next clock in BRAKE/IDLE. The FSM, dwell and safety behaviour are unchanged.

Test Plan:
- Single requester, basic drive: req_valid=4'b0100, r2 speed=30, deg=120, dir=1. Required: grant=4'b0100 after 1 clock, degree=120, speed reaches 30 after 15 ticks (ramp enabled).
- Preemption and hold: r3 granted, then r0 valid with strobe at 40 ms after that grant. Required: grant switches to r0 only at 100 ms; r3 dropping valid at 50 ms switches the grant immediately.
- Watchdog: r0 valid, strobes stop. Required: the grant leaves r0 200 ticks after the last strobe and goes to the next valid requester, or to none with speed ramping to 0.
- Direction reversal: owner changes tgt_dir from 1 to 0 at speed=20. Required: BRAKE for 10 ticks, DWELL for 300 ticks with speed=0 and busy_rev=1, then direction=0 and speed ramps up.
- Safety: forward at speed 30, forwardDistance falls from 25 to 19. Required: safety_stop=1 and speed=0 on the next clock; when forwardDistance returns to 25, safety_stop clears and speed ramps up.
- Async reset during DWELL: rst_n low. Required: all outputs take their reset values without waiting for a clock edge.
